// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score keeper: digit type and
// active-low gfe_dcba seven-segment patterns.
package score_pkg;

  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned SEG_W      = 7;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b111_1111;

  localparam logic [SEG_W-1:0] SEG_LUT [10] = '{
    7'b100_0000,  // 0
    7'b111_1001,  // 1
    7'b010_0100,  // 2
    7'b011_0000,  // 3
    7'b001_1001,  // 4
    7'b001_0010,  // 5
    7'b000_0010,  // 6
    7'b111_1000,  // 7
    7'b000_0000,  // 8
    7'b001_0000   // 9
  };

endpackage

// File: rtl/seg7_decode.sv
// One BCD digit to active-low seven-segment pattern; blank or non-decimal
// codes give an all-off pattern.
module seg7_decode
  import score_pkg::*;
(
  input  bcd_digit_t       digit,
  input  logic             blank,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (digit <= 4'd9)) begin
      seg = SEG_LUT[digit];
    end
  end

endmodule

// File: rtl/bcd_score_keeper.sv
// N-digit BCD score accumulator with bonus add, wrap/saturate overflow,
// end-of-game high-score capture and per-digit seven-segment outputs.
module bcd_score_keeper
  import score_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter bit          SATURATE  = 1'b0,
  parameter bit          BLANK_LZ  = 1'b1,
  parameter bit          TICK_EDGE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  run,
  input  logic                  tick,
  input  logic                  bonus_valid,
  input  logic [3:0]            bonus_val,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   high_bcd,
  output logic [7*DIGITS-1:0]   segments,
  output logic                  overflow,
  output logic                  new_high
);

  localparam int unsigned W = DIGIT_W * DIGITS;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic         tick_evt;
  logic [3:0]   bonus_amt;
  logic [3:0]   amt;
  logic [W-1:0] add_score;
  logic         carry_out;
  logic [DIGITS-1:0] gt_at;
  logic         score_gt_high;
  logic [DIGITS-1:0] lz_blank;
  logic         run_q;

  // Tick source: synchronised rising edge, or a synchronous pulse used as-is
  if (TICK_EDGE) begin : g_tick_sync
    logic sync_1, sync_2, sync_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_1 <= 1'b0;
        sync_2 <= 1'b0;
        sync_q <= 1'b0;
      end else begin
        sync_1 <= tick;
        sync_2 <= sync_1;
        sync_q <= sync_2;
      end
    end
    assign tick_evt = sync_2 & ~sync_q;
  end else begin : g_tick_pulse
    assign tick_evt = tick;
  end

  assign bonus_amt = (bonus_val > 4'd9) ? 4'd9 : bonus_val;
  assign amt       = 4'(tick_evt) + (bonus_valid ? bonus_amt : 4'd0);

  // Single-cycle ripple carry; only digit 0 sees amt, which can reach 10
  for (genvar i = 0; i < DIGITS; i++) begin : g_add
    logic [4:0] sum;
    logic       co;
    if (i == 0) begin : g_lsd
      assign sum = 5'(score_bcd[3:0]) + 5'(amt);
    end else begin : g_upper
      assign sum = 5'(score_bcd[4*i +: 4]) + 5'(g_add[i-1].co);
    end
    assign co = (sum >= 5'd10);
    assign add_score[4*i +: 4] = co ? 4'(sum - 5'd10) : sum[3:0];
  end

  assign carry_out = g_add[DIGITS-1].co;

  // MSD-first compare: digit i decides when every digit above it is equal
  for (genvar i = 0; i < DIGITS; i++) begin : g_cmp
    if (i == DIGITS - 1) begin : g_top
      assign gt_at[i] = score_bcd[4*i +: 4] > high_bcd[4*i +: 4];
    end else begin : g_low
      assign gt_at[i] = (score_bcd[W-1:4*(i+1)] == high_bcd[W-1:4*(i+1)]) &&
                        (score_bcd[4*i +: 4] > high_bcd[4*i +: 4]);
    end
  end

  assign score_gt_high = |gt_at;

  // Leading-zero blanking never applies to digit 0
  for (genvar i = 0; i < DIGITS; i++) begin : g_lz
    if (i == 0) begin : g_lsd
      assign lz_blank[i] = 1'b0;
    end else begin : g_upper
      assign lz_blank[i] = BLANK_LZ && (score_bcd[W-1:4*i] == '0);
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_seg
    seg7_decode u_seg (
      .digit (score_bcd[4*i +: 4]),
      .blank (lz_blank[i]),
      .seg   (segments[7*i +: 7])
    );
  end

  // Score, overflow and high-score registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score_bcd <= '0;
      high_bcd  <= '0;
      overflow  <= 1'b0;
      new_high  <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      run_q    <= run;
      new_high <= 1'b0;
      if (clear) begin
        score_bcd <= '0;
        overflow  <= 1'b0;
      end else if (run) begin
        if (carry_out) begin
          overflow  <= 1'b1;
          score_bcd <= SATURATE ? ALL_NINES : add_score;
        end else begin
          score_bcd <= add_score;
        end
      end
      if (run_q && !run && score_gt_high) begin
        high_bcd <= score_bcd;
        new_high <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_score_keeper.sv
// Bench for bcd_score_keeper: wrap, saturate and edge-tick instances driven
// in parallel, with a queue-based scoreboard against an integer model.
module tb_bcd_score_keeper;

  logic        clk;
  logic        reset_n;
  logic        clear;
  logic        run;
  logic        tick;
  logic        bonus_valid;
  logic [3:0]  bonus_val;

  logic [15:0] score_m, high_m, score_s, high_s, score_e, high_e;
  logic [27:0] seg_m, seg_s, seg_e;
  logic        ovf_m, ovf_s, ovf_e, nh_m, nh_s, nh_e;

  typedef struct {
    logic [15:0] ms;
    logic        mo;
    logic [15:0] ss;
    logic        so;
    logic [15:0] mh;
    logic        nh;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  int m_sc, s_sc, m_hi;
  bit m_ov, s_ov, prev_run;

  bcd_score_keeper #(.DIGITS(4), .SATURATE(1'b0), .BLANK_LZ(1'b1), .TICK_EDGE(1'b0)) u_dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .run(run), .tick(tick),
    .bonus_valid(bonus_valid), .bonus_val(bonus_val),
    .score_bcd(score_m), .high_bcd(high_m), .segments(seg_m),
    .overflow(ovf_m), .new_high(nh_m)
  );

  bcd_score_keeper #(.DIGITS(4), .SATURATE(1'b1), .BLANK_LZ(1'b0), .TICK_EDGE(1'b0)) u_sat (
    .clk(clk), .reset_n(reset_n), .clear(clear), .run(run), .tick(tick),
    .bonus_valid(bonus_valid), .bonus_val(bonus_val),
    .score_bcd(score_s), .high_bcd(high_s), .segments(seg_s),
    .overflow(ovf_s), .new_high(nh_s)
  );

  bcd_score_keeper #(.DIGITS(4), .SATURATE(1'b0), .BLANK_LZ(1'b1), .TICK_EDGE(1'b1)) u_edge (
    .clk(clk), .reset_n(reset_n), .clear(clear), .run(run), .tick(tick),
    .bonus_valid(bonus_valid), .bonus_val(bonus_val),
    .score_bcd(score_e), .high_bcd(high_e), .segments(seg_e),
    .overflow(ovf_e), .new_high(nh_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int d;
    d = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(d % 10);
      d = d / 10;
    end
    return r;
  endfunction

  // Drive one cycle, push the model's expectation, then pop and compare after the edge
  task automatic cycle(input logic t, input logic bv, input logic [3:0] bval,
                       input logic clr, input logic r);
    exp_t e;
    exp_t g;
    int   amt;
    tick = t; bonus_valid = bv; bonus_val = bval; clear = clr; run = r;
    amt = int'(t) + (bv ? ((bval > 4'd9) ? 9 : int'(bval)) : 0);
    e.nh = 1'b0;
    if (prev_run && !r && (m_sc > m_hi)) begin
      m_hi = m_sc;
      e.nh = 1'b1;
    end
    if (clr) begin
      m_sc = 0; m_ov = 0; s_sc = 0; s_ov = 0;
    end else if (r) begin
      m_sc = m_sc + amt;
      if (m_sc > 9999) begin m_sc = m_sc - 10000; m_ov = 1; end
      s_sc = s_sc + amt;
      if (s_sc > 9999) begin s_sc = 9999; s_ov = 1; end
    end
    prev_run = r;
    e.ms = to_bcd(m_sc); e.mo = m_ov; e.ss = to_bcd(s_sc); e.so = s_ov;
    e.mh = to_bcd(m_hi);
    sb.push_back(e);
    @(posedge clk); #1;
    g = sb.pop_front();
    checks += 6;
    if (score_m !== g.ms) begin errors++; $display("FAIL sb_score_wrap: got %h expected %h", score_m, g.ms); end
    if (ovf_m !== g.mo) begin errors++; $display("FAIL sb_ovf_wrap: got %b expected %b", ovf_m, g.mo); end
    if (score_s !== g.ss) begin errors++; $display("FAIL sb_score_sat: got %h expected %h", score_s, g.ss); end
    if (ovf_s !== g.so) begin errors++; $display("FAIL sb_ovf_sat: got %b expected %b", ovf_s, g.so); end
    if (high_m !== g.mh) begin errors++; $display("FAIL sb_high: got %h expected %h", high_m, g.mh); end
    if (nh_m !== g.nh) begin errors++; $display("FAIL sb_new_high: got %b expected %b", nh_m, g.nh); end
  endtask

  task automatic model_reset();
    m_sc = 0; s_sc = 0; m_hi = 0; m_ov = 0; s_ov = 0; prev_run = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clear = 0; run = 0; tick = 0; bonus_valid = 0; bonus_val = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks += 7;
    if (score_m !== 16'h0000) begin errors++; $display("FAIL reset_score: got %h expected 0000", score_m); end
    if (high_m !== 16'h0000) begin errors++; $display("FAIL reset_high: got %h expected 0000", high_m); end
    if (ovf_m !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf_m); end
    if (nh_m !== 1'b0) begin errors++; $display("FAIL reset_new_high: got %b expected 0", nh_m); end
    if (seg_m !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin errors++; $display("FAIL reset_seg_blank: got %h expected %h", seg_m, {7'h7F, 7'h7F, 7'h7F, 7'h40}); end
    if (seg_s !== {4{7'h40}}) begin errors++; $display("FAIL reset_seg_noblank: got %h expected %h", seg_s, {4{7'h40}}); end
    if (score_e !== 16'h0000) begin errors++; $display("FAIL reset_score_edge: got %h expected 0000", score_e); end
    reset_n = 1'b1;
  endtask

  task automatic test_ticks();
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    end
    checks += 4;
    if (score_m !== 16'h0012) begin errors++; $display("FAIL ticks_score: got %h expected 0012", score_m); end
    if (seg_m[13:7] !== 7'b111_1001) begin errors++; $display("FAIL ticks_seg_d1: got %b expected 1111001", seg_m[13:7]); end
    if (seg_m[27:14] !== {7'h7F, 7'h7F}) begin errors++; $display("FAIL ticks_seg_blank: got %h expected 3fff", seg_m[27:14]); end
    if (seg_s !== {7'h40, 7'h40, 7'h79, 7'h24}) begin errors++; $display("FAIL ticks_seg_noblank: got %h expected %h", seg_s, {7'h40, 7'h40, 7'h79, 7'h24}); end
  endtask

  task automatic test_bonus();
    cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 4'd9, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 4'd5, 1'b0, 1'b1);
    checks++;
    if (score_m !== 16'h0095) begin errors++; $display("FAIL bonus_95: got %h expected 0095", score_m); end
    cycle(1'b1, 1'b1, 4'd9, 1'b0, 1'b1);
    checks++;
    if (score_m !== 16'h0105) begin errors++; $display("FAIL bonus_tick_carry: got %h expected 0105", score_m); end
    cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 4'd12, 1'b0, 1'b1);
    checks += 2;
    if (score_m !== 16'h0009) begin errors++; $display("FAIL bonus_clamp: got %h expected 0009", score_m); end
    if (seg_m[6:0] !== 7'b001_0000) begin errors++; $display("FAIL bonus_seg9: got %b expected 0010000", seg_m[6:0]); end
  endtask

  task automatic test_overflow();
    cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    for (int i = 0; i < 999; i++) cycle(1'b1, 1'b1, 4'd9, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 4'd8, 1'b0, 1'b1);
    checks++;
    if (score_m !== 16'h9998) begin errors++; $display("FAIL ovf_setup: got %h expected 9998", score_m); end
    cycle(1'b0, 1'b1, 4'd5, 1'b0, 1'b1);
    checks += 4;
    if (score_m !== 16'h0003) begin errors++; $display("FAIL ovf_wrap_score: got %h expected 0003", score_m); end
    if (ovf_m !== 1'b1) begin errors++; $display("FAIL ovf_wrap_flag: got %b expected 1", ovf_m); end
    if (score_s !== 16'h9999) begin errors++; $display("FAIL ovf_sat_score: got %h expected 9999", score_s); end
    if (ovf_s !== 1'b1) begin errors++; $display("FAIL ovf_sat_flag: got %b expected 1", ovf_s); end
    cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    checks += 2;
    if (score_s !== 16'h9999) begin errors++; $display("FAIL ovf_sat_hold: got %h expected 9999", score_s); end
    if (score_m !== 16'h0005) begin errors++; $display("FAIL ovf_wrap_cont: got %h expected 0005", score_m); end
    cycle(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
    checks += 3;
    if (score_m !== 16'h0000) begin errors++; $display("FAIL clear_over_tick: got %h expected 0000", score_m); end
    if (ovf_m !== 1'b0) begin errors++; $display("FAIL clear_ovf_wrap: got %b expected 0", ovf_m); end
    if (ovf_s !== 1'b0) begin errors++; $display("FAIL clear_ovf_sat: got %b expected 0", ovf_s); end
  endtask

  task automatic test_edge_tick();
    logic [15:0] exp_e;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    checks++;
    if (score_e !== 16'h0000) begin errors++; $display("FAIL edge_cleared: got %h expected 0000", score_e); end
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
      exp_e = (k >= 3) ? 16'h0001 : 16'h0000;
      checks++;
      if (score_e !== exp_e) begin errors++; $display("FAIL edge_held_%0d: got %h expected %h", k, score_e, exp_e); end
    end
    cycle(1'b0, 1'b1, 4'd3, 1'b0, 1'b1);
    checks++;
    if (score_e !== 16'h0004) begin errors++; $display("FAIL edge_bonus: got %h expected 0004", score_e); end
  endtask

  task automatic test_high();
    cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 4'd9, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 4'd6, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    checks += 2;
    if (high_m !== 16'h0042) begin errors++; $display("FAIL high_capture: got %h expected 0042", high_m); end
    if (nh_m !== 1'b1) begin errors++; $display("FAIL high_pulse: got %b expected 1", nh_m); end
    cycle(1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
    checks += 2;
    if (nh_m !== 1'b0) begin errors++; $display("FAIL high_pulse_len: got %b expected 0", nh_m); end
    if (score_m !== 16'h0042) begin errors++; $display("FAIL idle_hold: got %h expected 0042", score_m); end
    cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 4'd9, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 4'd3, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    checks += 2;
    if (high_m !== 16'h0042) begin errors++; $display("FAIL high_keep: got %h expected 0042", high_m); end
    if (nh_m !== 1'b0) begin errors++; $display("FAIL high_no_pulse: got %b expected 0", nh_m); end
  endtask

  task automatic test_clear_keep_high();
    cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
    checks += 2;
    if (score_m !== 16'h0000) begin errors++; $display("FAIL clear_mid_score: got %h expected 0000", score_m); end
    if (high_m !== 16'h0042) begin errors++; $display("FAIL clear_mid_high: got %h expected 0042", high_m); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    tick = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checks += 5;
    if (score_m !== 16'h0000) begin errors++; $display("FAIL rst_mid_score: got %h expected 0000", score_m); end
    if (high_m !== 16'h0000) begin errors++; $display("FAIL rst_mid_high: got %h expected 0000", high_m); end
    if (ovf_m !== 1'b0 || nh_m !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: got %b%b expected 00", ovf_m, nh_m); end
    if (seg_m !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin errors++; $display("FAIL rst_mid_seg: got %h expected %h", seg_m, {7'h7F, 7'h7F, 7'h7F, 7'h40}); end
    if (score_e !== 16'h0000) begin errors++; $display("FAIL rst_mid_edge: got %h expected 0000", score_e); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    checks++;
    if (score_m !== 16'h0001) begin errors++; $display("FAIL rst_restart: got %h expected 0001", score_m); end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_ticks();
    test_bonus();
    test_overflow();
    test_edge_tick();
    test_high();
    test_clear_keep_high();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
